pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use / branch-operand /
// multi-cycle-unit stalls, and control-transfer flush handling for a classic 5-stage pipe.
module pipe_hazard_ctrl #(
  parameter int unsigned RW         = 5,
  parameter int unsigned MDU_LAT    = 4,
  parameter int unsigned BR_MODE    = 0,
  parameter int unsigned BR_PENALTY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_wreg,
  input  logic          id_load,
  input  logic          id_mdu,
  input  logic          id_ctrl,
  input  logic          id_taken,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_wdst,
  output logic          pc_stall,
  output logic          ifid_stall,
  output logic          ifid_flush,
  output logic          idex_bubble,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          mdu_busy
);

  logic          ex_valid, ex_wreg, ex_load;
  logic [RW-1:0] ex_dst;
  logic          mem_valid, mem_wreg, mem_load;
  logic [RW-1:0] mem_dst;
  logic [3:0]    mdu_cnt;
  logic [RW-1:0] mdu_dst;
  logic [1:0]    shadow_cnt;

  logic shadow_act, id_live, hazard, accept;
  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic hz_load, hz_br, hz_mdu, br_flush_now;

  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit,
                                         input logic ex_ld, input logic mem_ld);
    if (ex_hit && !ex_ld)   return 2'b01;
    else if (mem_hit && mem_ld) return 2'b11;
    else if (mem_hit)       return 2'b10;
    else                    return 2'b00;
  endfunction

  assign shadow_act = (shadow_cnt != '0);
  assign mdu_busy   = (mdu_cnt != '0);

  always_comb begin
    ex_hit_a  = id_use_rs & (id_rs != '0) & ex_valid  & ex_wreg  & (ex_dst  == id_rs);
    ex_hit_b  = id_use_rt & (id_rt != '0) & ex_valid  & ex_wreg  & (ex_dst  == id_rt);
    mem_hit_a = id_use_rs & (id_rs != '0) & mem_valid & mem_wreg & (mem_dst == id_rs);
    mem_hit_b = id_use_rt & (id_rt != '0) & mem_valid & mem_wreg & (mem_dst == id_rt);

    hz_load = (ex_hit_a | ex_hit_b) & ex_load;
    hz_br   = id_ctrl & (ex_hit_a | ex_hit_b);
    hz_mdu  = mdu_busy & (id_mdu |
              ((mdu_dst != '0) & ((id_use_rs & (id_rs == mdu_dst)) |
                                  (id_use_rt & (id_rt == mdu_dst)))));

    // While the branch shadow runs, the ID slot holds a wrong-path fetch and is ignored
    id_live = id_valid & ~shadow_act;
    hazard  = id_live & (hz_load | hz_br | hz_mdu);
    accept  = id_live & ~hazard;

    br_flush_now = accept & id_ctrl & ((BR_MODE == 0) | id_taken);

    pc_stall    = hazard | shadow_act;
    ifid_stall  = hazard;
    ifid_flush  = br_flush_now | shadow_act;
    idex_bubble = hazard | shadow_act;

    fwd_a = id_live ? fwd_sel(ex_hit_a, mem_hit_a, ex_load, mem_load) : 2'b00;
    fwd_b = id_live ? fwd_sel(ex_hit_b, mem_hit_b, ex_load, mem_load) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_wreg    <= 1'b0;
      ex_load    <= 1'b0;
      ex_dst     <= '0;
      mem_valid  <= 1'b0;
      mem_wreg   <= 1'b0;
      mem_load   <= 1'b0;
      mem_dst    <= '0;
      mdu_cnt    <= '0;
      mdu_dst    <= '0;
      shadow_cnt <= '0;
    end else begin
      ex_valid  <= id_valid & ~idex_bubble;
      ex_wreg   <= id_wreg & ~id_mdu;
      ex_load   <= id_load;
      ex_dst    <= id_wdst;
      mem_valid <= ex_valid;
      mem_wreg  <= ex_wreg;
      mem_load  <= ex_load;
      mem_dst   <= ex_dst;

      if (accept && id_mdu) begin
        mdu_cnt <= 4'(MDU_LAT);
        mdu_dst <= id_wdst;
      end else if (mdu_busy) begin
        mdu_cnt <= mdu_cnt - 4'd1;
      end

      // Cycle t flushes combinationally; the counter covers t+1 .. t+BR_PENALTY-1
      if ((BR_MODE == 0) && accept && id_ctrl)
        shadow_cnt <= 2'(BR_PENALTY - 1);
      else if (shadow_act)
        shadow_cnt <= shadow_cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a BR_MODE 0 instance and a BR_MODE 1 instance share
// the ID stimulus; status = {pc_stall, ifid_stall, ifid_flush, idex_bubble, mdu_busy, fwd_a, fwd_b}.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0, id_wreg = 1'b0;
  logic       id_load = 1'b0, id_mdu = 1'b0, id_ctrl = 1'b0, id_taken = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_wdst = '0;

  logic       pc_stall0, ifid_stall0, ifid_flush0, idex_bubble0, mdu_busy0;
  logic [1:0] fwd_a0, fwd_b0;
  logic       pc_stall1, ifid_stall1, ifid_flush1, idex_bubble1, mdu_busy1;
  logic [1:0] fwd_a1, fwd_b1;
  logic [8:0] st0, st1, exp;

  int checks = 0;
  int errors = 0;

  assign st0 = {pc_stall0, ifid_stall0, ifid_flush0, idex_bubble0, mdu_busy0, fwd_a0, fwd_b0};
  assign st1 = {pc_stall1, ifid_stall1, ifid_flush1, idex_bubble1, mdu_busy1, fwd_a1, fwd_b1};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RW(5), .MDU_LAT(4), .BR_MODE(0), .BR_PENALTY(2)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_load(id_load), .id_mdu(id_mdu), .id_ctrl(id_ctrl),
    .id_taken(id_taken), .id_rs(id_rs), .id_rt(id_rt), .id_wdst(id_wdst),
    .pc_stall(pc_stall0), .ifid_stall(ifid_stall0), .ifid_flush(ifid_flush0),
    .idex_bubble(idex_bubble0), .fwd_a(fwd_a0), .fwd_b(fwd_b0), .mdu_busy(mdu_busy0)
  );

  pipe_hazard_ctrl #(.RW(5), .MDU_LAT(4), .BR_MODE(1), .BR_PENALTY(2)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_load(id_load), .id_mdu(id_mdu), .id_ctrl(id_ctrl),
    .id_taken(id_taken), .id_rs(id_rs), .id_rt(id_rt), .id_wdst(id_wdst),
    .pc_stall(pc_stall1), .ifid_stall(ifid_stall1), .ifid_flush(ifid_flush1),
    .idex_bubble(idex_bubble1), .fwd_a(fwd_a1), .fwd_b(fwd_b1), .mdu_busy(mdu_busy1)
  );

  // One pipeline cycle: apply ID fields just after the edge, return at the falling edge
  task automatic drive(input logic v, us, ut, wr, ld, md, ct, tk,
                       input logic [4:0] rs, rt, wd);
    @(posedge clk); #1;
    id_valid = v;  id_use_rs = us; id_use_rt = ut; id_wreg = wr;
    id_load  = ld; id_mdu = md;    id_ctrl = ct;   id_taken = tk;
    id_rs = rs; id_rt = rt; id_wdst = wd;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    exp = 9'b0;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL reset_m0: status=%b expected %b", st0, exp); end
    checks++; if (st1 !== exp) begin errors++; $display("FAIL reset_m1: status=%b expected %b", st1, exp); end
    idle();
  endtask

  task automatic test_fwd_ex();
    drive(1, 1, 1, 1, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);   // add r3,r1,r2
    exp = 9'b0;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL fwd_add: status=%b expected %b", st0, exp); end
    drive(1, 1, 1, 1, 0, 0, 0, 0, 5'd3, 5'd3, 5'd5);   // or r5,r3,r3
    exp = 9'b0_0_0_0_0_01_01;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL fwd_ex: status=%b expected %b", st0, exp); end
    drive(1, 1, 0, 1, 0, 0, 0, 0, 5'd3, 5'd0, 5'd6);   // r3 now in MEM
    exp = 9'b0_0_0_0_0_10_00;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL fwd_mem: status=%b expected %b", st0, exp); end
    idle(); idle();
  endtask

  task automatic test_load_use();
    drive(1, 1, 0, 1, 1, 0, 0, 0, 5'd1, 5'd0, 5'd4);   // lw r4
    exp = 9'b0;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL lu_lw: status=%b expected %b", st0, exp); end
    drive(1, 1, 0, 1, 0, 0, 0, 0, 5'd4, 5'd0, 5'd6);   // add r6,r4
    exp = 9'b1_1_0_1_0_00_00;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL lu_stall: status=%b expected %b", st0, exp); end
    drive(1, 1, 0, 1, 0, 0, 0, 0, 5'd4, 5'd0, 5'd6);
    exp = 9'b0_0_0_0_0_11_00;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL lu_fwd: status=%b expected %b", st0, exp); end
    idle(); idle();
  endtask

  task automatic test_newest();
    drive(1, 0, 0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd2);   // lw r2
    drive(1, 0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd2);   // add r2
    exp = 9'b0;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL nw_add: status=%b expected %b", st0, exp); end
    drive(1, 1, 1, 1, 0, 0, 0, 0, 5'd2, 5'd2, 5'd9);
    exp = 9'b0_0_0_0_0_01_01;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL nw_fwd: status=%b expected %b", st0, exp); end
    idle(); idle();
  endtask

  task automatic test_reg0();
    drive(1, 0, 0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);   // lw r0
    drive(1, 1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd8);
    exp = 9'b0;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL r0_ex: status=%b expected %b", st0, exp); end
    drive(1, 1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd8);
    checks++; if (st0 !== exp) begin errors++; $display("FAIL r0_mem: status=%b expected %b", st0, exp); end
    drive(0, 1, 1, 1, 0, 0, 1, 1, 5'd8, 5'd8, 5'd0);   // invalid slot matching EX r8
    checks++; if (st0 !== exp) begin errors++; $display("FAIL inv_slot: status=%b expected %b", st0, exp); end
    idle(); idle();
  endtask

  task automatic test_mdu();
    drive(1, 1, 1, 1, 0, 1, 0, 0, 5'd1, 5'd2, 5'd7);   // mul r7
    exp = 9'b0;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL mdu_issue: status=%b expected %b", st0, exp); end
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 1, 0, 0, 0, 0, 5'd7, 5'd0, 5'd8);
      exp = 9'b1_1_0_1_1_00_00;
      checks++; if (st0 !== exp) begin errors++; $display("FAIL mdu_stall%0d: status=%b expected %b", i, st0, exp); end
    end
    drive(1, 1, 0, 1, 0, 0, 0, 0, 5'd7, 5'd0, 5'd8);
    exp = 9'b0;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL mdu_release: status=%b expected %b", st0, exp); end
    drive(1, 1, 1, 1, 0, 1, 0, 0, 5'd1, 5'd2, 5'd7);
    checks++; if (st0 !== exp) begin errors++; $display("FAIL mdu_issue2: status=%b expected %b", st0, exp); end
    drive(1, 0, 0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd9);   // second mul while busy
    exp = 9'b1_1_0_1_1_00_00;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL mdu_struct: status=%b expected %b", st0, exp); end
    idle();
    exp = 9'b0_0_0_0_1_00_00;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL mdu_idle: status=%b expected %b", st0, exp); end
    idle(); idle(); idle(); idle();
  endtask

  task automatic test_branch();
    drive(1, 1, 1, 0, 0, 0, 1, 1, 5'd1, 5'd9, 5'd0);   // beq at t
    exp = 9'b0_0_1_0_0_00_00;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL br_t: status=%b expected %b", st0, exp); end
    drive(1, 1, 0, 1, 0, 0, 0, 0, 5'd1, 5'd0, 5'd5);
    exp = 9'b1_0_1_1_0_00_00;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL br_t1: status=%b expected %b", st0, exp); end
    idle();
    exp = 9'b0;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL br_t2: status=%b expected %b", st0, exp); end
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 0, 1, 1, 0, 0, 0, 5'd1, 5'd0, 5'd4);   // lw r4
    drive(1, 1, 1, 0, 0, 0, 1, 1, 5'd4, 5'd9, 5'd0);   // beq r4: load-use + branch hazard
    exp = 9'b1_1_0_1_0_00_00;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL b2b_stall: status=%b expected %b", st0, exp); end
    drive(1, 1, 1, 0, 0, 0, 1, 1, 5'd4, 5'd9, 5'd0);
    exp = 9'b0_0_1_0_0_11_00;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL b2b_accept: status=%b expected %b", st0, exp); end
    idle();
    exp = 9'b1_0_1_1_0_00_00;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL b2b_shadow: status=%b expected %b", st0, exp); end
    idle();
    exp = 9'b0;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL b2b_done: status=%b expected %b", st0, exp); end
  endtask

  task automatic test_branch_mode1();
    rst = 1'b1;
    idle();
    rst = 1'b0;
    drive(1, 1, 1, 0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd0);   // beq not taken
    exp = 9'b0;
    checks++; if (st1 !== exp) begin errors++; $display("FAIL m1_nt: status=%b expected %b", st1, exp); end
    exp = 9'b0_0_1_0_0_00_00;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL m0_nt: status=%b expected %b", st0, exp); end
    drive(1, 1, 1, 0, 0, 0, 1, 1, 5'd1, 5'd2, 5'd0);   // beq taken
    exp = 9'b0_0_1_0_0_00_00;
    checks++; if (st1 !== exp) begin errors++; $display("FAIL m1_tk: status=%b expected %b", st1, exp); end
    exp = 9'b1_0_1_1_0_00_00;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL m0_shadow: status=%b expected %b", st0, exp); end
    idle();
    exp = 9'b0;
    checks++; if (st1 !== exp) begin errors++; $display("FAIL m1_after: status=%b expected %b", st1, exp); end
    idle();
  endtask

  task automatic test_mdu_reset();
    drive(1, 1, 1, 1, 0, 1, 0, 0, 5'd1, 5'd2, 5'd7);   // mul r7
    drive(1, 1, 0, 1, 0, 0, 0, 0, 5'd7, 5'd0, 5'd8);
    drive(1, 1, 0, 1, 0, 0, 0, 0, 5'd7, 5'd0, 5'd8);
    exp = 9'b1_1_0_1_1_00_00;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL mrst_busy: status=%b expected %b", st0, exp); end
    rst = 1'b1;
    drive(1, 1, 0, 1, 0, 0, 0, 0, 5'd7, 5'd0, 5'd8);
    rst = 1'b0;
    exp = 9'b0;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL mrst_clear: status=%b expected %b", st0, exp); end
    idle();
  endtask

  task automatic test_shadow_reset();
    drive(1, 1, 1, 0, 0, 0, 1, 1, 5'd1, 5'd2, 5'd0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    exp = 9'b0;
    checks++; if (st0 !== exp) begin errors++; $display("FAIL srst_clear: status=%b expected %b", st0, exp); end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, run incomplete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fwd_ex();
    test_load_use();
    test_newest();
    test_reg0();
    test_mdu();
    test_branch();
    test_back_to_back();
    test_branch_mode1();
    test_mdu_reset();
    test_shadow_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
